// File: rtl/rom_load_ctrl_pkg.sv
// Shared constants and state encoding for the ROM initialisation loader.
package rom_load_ctrl_pkg;

  localparam int ROM_DEPTH = 16384;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);
  localparam int REM_WIDTH = ROM_AW + 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/rom_load_ctrl.sv
// Streams bytes into the ROM init write port, holding the CPU off until the
// image is written, then pulses done and exposes a running byte checksum.
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = ROM_DEPTH,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  input  logic                     abort,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  output logic                     we_b,
  output logic [ADDRESS_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0]    din_b,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    checksum
);

  localparam int RW = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [RW-1:0]            r_rem;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_addr_b;
  logic [DATA_WIDTH-1:0]    r_din;
  logic [DATA_WIDTH-1:0]    r_csum;
  logic                     r_done;
  logic [ADDRESS_WIDTH-1:0] w_addr_next;

  // Address counter wraps modulo DEPTH, which need not be a power of two.
  always_comb begin
    if (r_addr == LAST_ADDR) begin
      w_addr_next = {ADDRESS_WIDTH{1'b0}};
    end else begin
      w_addr_next = r_addr + ADDRESS_WIDTH'(1);
    end
  end

  // Load sequencer with address, remaining-count and checksum counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_addr   <= {ADDRESS_WIDTH{1'b0}};
      r_rem    <= {RW{1'b0}};
      r_we     <= 1'b0;
      r_addr_b <= {ADDRESS_WIDTH{1'b0}};
      r_din    <= {DATA_WIDTH{1'b0}};
      r_csum   <= {DATA_WIDTH{1'b0}};
      r_done   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_csum <= {DATA_WIDTH{1'b0}};
            if (length != {RW{1'b0}}) begin
              r_addr  <= base_addr;
              r_rem   <= length;
              r_state <= ST_LOAD;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          // abort wins over a same-cycle byte, which is then dropped.
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (in_valid) begin
            r_we     <= 1'b1;
            r_addr_b <= r_addr;
            r_din    <= in_data;
            r_csum   <= r_csum + in_data;
            r_addr   <= w_addr_next;
            r_rem    <= r_rem - RW'(1);
            if (r_rem == RW'(1)) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          r_state <= ST_IDLE;
          r_done  <= !abort;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_LOAD);
  assign busy     = (r_state != ST_IDLE);
  assign cpu_hold = (r_state != ST_IDLE);
  assign we_b     = r_we;
  assign addr_b   = r_addr_b;
  assign din_b    = r_din;
  assign done     = r_done;
  assign checksum = r_csum;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench: tests queue expected ROM writes and done checksums, a
// negedge monitor pops and compares them as the DUT presents them.
module tb_rom_load_ctrl;
  import rom_load_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ROM_AW-1:0] base_addr = '0;
  logic [REM_WIDTH-1:0] length = '0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready, we_b, busy, cpu_hold, done;
  logic [ROM_AW-1:0] addr_b;
  logic [7:0]        din_b, checksum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  logic prev_acc = 1'b0;
  logic [ROM_AW+7:0] wr_q[$];
  logic [7:0]        done_q[$];

  rom_load_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .length(length), .abort(abort), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: write latency, scoreboard pops for writes and done pulses.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_acc = 1'b0;
    end else begin
      check("we_latency", {31'd0, we_b}, {31'd0, prev_acc});
      if (we_b) begin
        if (wr_q.size() == 0) check("unexpected_write", {18'd0, addr_b}, 32'hFFFF_FFFF);
        else check("write_addr_data", {14'd0, addr_b, din_b}, {14'd0, wr_q.pop_front()});
      end
      if (done) begin
        done_cyc = cyc;
        check("done_release", {30'd0, busy, cpu_hold}, 32'd0);
        if (done_q.size() == 0) check("unexpected_done", {24'd0, checksum}, 32'hFFFF_FFFF);
        else check("done_checksum", {24'd0, checksum}, {24'd0, done_q.pop_front()});
      end
      prev_acc = in_valid && in_ready && !abort;
      if (prev_acc) acc_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ROM_AW-1:0] b, input logic [REM_WIDTH-1:0] l);
    start = 1'b1; base_addr = b; length = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = d;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_wr(input logic [ROM_AW-1:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
  endtask

  task automatic settle(input string name);
    repeat (4) tick();
    check({name, "_wr_left"}, wr_q.size(), 32'd0);
    check({name, "_done_left"}, done_q.size(), 32'd0);
    check({name, "_idle"}, {29'd0, busy, cpu_hold, in_ready}, 32'd0);
  endtask

  initial begin
    #22 reset_n = 1'b1;
    check("reset_outputs", {7'd0, in_ready, we_b, busy, cpu_hold, done, addr_b, din_b, checksum}, 32'd0);
    tick();

    // Basic load
    push_wr(14'h0000, 8'h11); push_wr(14'h0001, 8'h22);
    push_wr(14'h0002, 8'h33); push_wr(14'h0003, 8'h44);
    done_q.push_back(8'hAA);
    do_start(14'h0000, 15'd4);
    check("load_busy", {30'd0, busy, cpu_hold}, 32'd3);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    settle("basic");
    check("basic_checksum", {24'd0, checksum}, 32'h0000_00AA);

    // Address wrap
    push_wr(14'h3FFE, 8'h01); push_wr(14'h3FFF, 8'h02);
    push_wr(14'h0000, 8'h03); push_wr(14'h0001, 8'h04);
    done_q.push_back(8'h0A);
    do_start(14'h3FFE, 15'd4);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    settle("wrap");

    // Stalled stream: valid pattern 1,0,0,1,0,1
    push_wr(14'h0010, 8'h05); push_wr(14'h0011, 8'h06); push_wr(14'h0012, 8'h07);
    done_q.push_back(8'h12);
    do_start(14'h0010, 15'd3);
    send(8'h05, 0); send(8'h06, 2); send(8'h07, 1);
    check("stall_ready_low", {31'd0, in_ready}, 32'd0);
    settle("stall");
    check("stall_done_gap", done_cyc - acc_cyc, 32'd2);

    // Abort with the 5th byte
    push_wr(14'h0200, 8'h10); push_wr(14'h0201, 8'h20);
    push_wr(14'h0202, 8'h30); push_wr(14'h0203, 8'h40);
    do_start(14'h0200, 15'd8);
    send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h40, 0);
    in_valid = 1'b1; in_data = 8'h50; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    check("abort_release", {30'd0, busy, cpu_hold}, 32'd0);
    settle("abort");
    check("abort_checksum", {24'd0, checksum}, 32'h0000_00A0);

    // Zero length start
    done_q.push_back(8'h00);
    do_start(14'h0123, 15'd0);
    settle("zero");

    // Start during a load is ignored
    push_wr(14'h0300, 8'hAB); push_wr(14'h0301, 8'hCD);
    done_q.push_back(8'h78);
    do_start(14'h0300, 15'd2);
    send(8'hAB, 0);
    start = 1'b1; base_addr = 14'h0000; length = 15'd5;
    send(8'hCD, 0);
    start = 1'b0;
    settle("ignored_start");

    // Reset mid-load
    push_wr(14'h0400, 8'h01); push_wr(14'h0401, 8'h02);
    do_start(14'h0400, 15'd6);
    send(8'h01, 0); send(8'h02, 0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {7'd0, in_ready, we_b, busy, cpu_hold, done, addr_b, din_b, checksum}, 32'd0);
    #3 reset_n = 1'b1;
    tick();
    push_wr(14'h0100, 8'h5A);
    done_q.push_back(8'h5A);
    do_start(14'h0100, 15'd1);
    send(8'h5A, 0);
    check("single_ready_low", {31'd0, in_ready}, 32'd0);
    settle("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
